bp_access_scheduler: RTL and testbench
======================================

# bp_access_scheduler

Single-port access scheduler for the branch-predictor tables. Each cycle it grants the table port either to the fetch-side prediction lookup or to a retire-side update drawn from an internal outcome FIFO. It buffers resolved branch outcomes, gives lookups priority, and bounds update starvation. It sits between fetch/retire logic and the predictor table (local/global/choice) banks.

## Interface
- PC_W, 10, branch PC width.
- QDEPTH, 4, outcome FIFO depth (power of 2, ≥2).
- STARVE_MAX, 3, max consecutive lookup grants while an update is pending (≥1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pred_req  in  1  lookup request this cycle.
- pred_pc  in  PC_W  lookup PC.
- pred_grant  out  1  lookup owns table port this cycle (combinational).
- pred_rsp_valid  out  1  lookup result valid (registered, 1 cycle after grant).
- pred_rsp_taken  out  1  prediction; equals tbl_rdata while pred_rsp_valid=1.
- upd_valid  in  1  resolved-branch outcome offered.
- upd_pc  in  PC_W  resolved branch PC.
- upd_taken  in  1  actual direction.
- upd_ready  out  1  FIFO can accept (count < QDEPTH).
- tbl_en  out  1  table access this cycle.
- tbl_we  out  1  1=write (update), 0=read (lookup).
- tbl_pc  out  PC_W  table index PC.
- tbl_wdata  out  1  outcome to write.
- tbl_rdata  in  1  table read data, valid the cycle after a read.
- queue_count  out  $clog2(QDEPTH)+1  FIFO occupancy.

## Operation
- State: FIFO of {pc, taken} (head/tail pointers with wrap, occupancy count), starve_cnt (0..STARVE_MAX), rsp_valid flag.
- Push: upd_valid && upd_ready writes {upd_pc, upd_taken} at tail. upd_valid while upd_ready=0 is ignored (no push, no error).
- force_upd = (starve_cnt == STARVE_MAX) && (queue_count != 0).
- Per-cycle slot selection (combinational, priority order):
  - LOOKUP: pred_req && !force_upd → pred_grant=1, tbl_en=1, tbl_we=0, tbl_pc=pred_pc.
  - UPDATE: else if queue_count != 0 → tbl_en=1, tbl_we=1, tbl_pc=head.pc, tbl_wdata=head.taken; head pops at the clock edge.
  - IDLE: else tbl_en=0, tbl_we=0, tbl_pc=0, tbl_wdata=0.
- starve_cnt next value: LOOKUP with queue_count != 0 → +1 (saturates at STARVE_MAX); UPDATE slot or queue empty → 0.
- Simultaneous push and pop: both happen; count unchanged; a push into an empty queue cannot pop in the same cycle (occupancy checked before push).
- upd_ready is computed from the current count only. There is no same-cycle pop-to-push bypass when full.
- Pointer wrap modulo QDEPTH; FIFO order preserved.
- Requester drops or changes pred_req freely; no hold requirement because grant is same-cycle.

## Timing
- Reset (async, immediate): queue_count=0, pointers=0, starve_cnt=0, pred_rsp_valid=0. Hence upd_ready=1, tbl_en=0 unless pred_req=1, pred_grant=pred_req.
- Reset mid-operation discards all queued outcomes. No tbl_we occurs for them afterward.
- Lookup latency: grant in cycle N, pred_rsp_valid=1 and pred_rsp_taken=tbl_rdata in cycle N+1. Back-to-back lookups give back-to-back responses.
- Update latency: outcome accepted at edge E appears at tbl_we no earlier than the cycle after E. Worst case, with the queue at position k, the wait is (k+1)·(STARVE_MAX+1) cycles under continuous lookups.
- Table port is never read and written in the same cycle.

## Test plan
- Reset: assert reset with 3 entries queued → queue_count=0, upd_ready=1, pred_rsp_valid=0 immediately. After release, no tbl_we seen over 10 cycles with no new pushes.
- Lookup: pred_req=1, pred_pc=0x3A0, queue empty → same cycle pred_grant=1, tbl_en=1, tbl_we=0, tbl_pc=0x3A0. Drive tbl_rdata=1 next cycle → pred_rsp_valid=1, pred_rsp_taken=1.
- Update: push {0x010, 1}, pred_req=0 → next cycle queue_count=1, tbl_we=1, tbl_pc=0x010, tbl_wdata=1; following cycle queue_count=0, tbl_en=0.
- Starvation: queue 1 entry, hold pred_req=1 → pred_grant=1 for 3 cycles, 4th cycle pred_grant=0 with tbl_we=1, 5th cycle pred_grant=1 and starve_cnt=0.
- Full/wrap: hold pred_req=1, offer 8 back-to-back outcomes (pc 0x100..0x107, alternating taken) → upd_ready drops at queue_count=4, rejected offers are not written, and accepted entries reach tbl_we exactly once each in acceptance order across pointer wrap.
- Simultaneous push/pop: queue 2 entries, pred_req=0, push one each cycle for 4 cycles → queue_count stays 2, writes in FIFO order.

Source files
------------

// File: rtl/bp_access_scheduler.sv
// Purpose: arbitrates the single branch-predictor table port between fetch lookups and queued retire updates.
// Latency: lookup grant is combinational and its response is one cycle later; a queued update is written no earlier than the cycle after it is accepted.
// Backpressure: upd_ready drops while the outcome FIFO is full; lookups have priority until STARVE_MAX consecutive grants, then one update is forced.
//
// Ports:
//   clock, reset                      - rising-edge clock, async active-high reset
//   pred_req/pred_pc                  - lookup request and PC (same-cycle pred_grant)
//   pred_rsp_valid/pred_rsp_taken     - registered lookup response (tbl_rdata pass-through)
//   upd_valid/upd_pc/upd_taken        - resolved outcome offer, accepted when upd_ready
//   tbl_en/tbl_we/tbl_pc/tbl_wdata    - table port command; tbl_rdata returns read data next cycle
//   queue_count                       - outcome FIFO occupancy
module bp_access_scheduler #(
  parameter int PC_W       = 10,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pred_req,
  input  logic [PC_W-1:0]           pred_pc,
  output logic                      pred_grant,
  output logic                      pred_rsp_valid,
  output logic                      pred_rsp_taken,
  input  logic                      upd_valid,
  input  logic [PC_W-1:0]           upd_pc,
  input  logic                      upd_taken,
  output logic                      upd_ready,
  output logic                      tbl_en,
  output logic                      tbl_we,
  output logic [PC_W-1:0]           tbl_pc,
  output logic                      tbl_wdata,
  input  logic                      tbl_rdata,
  output logic [$clog2(QDEPTH):0]   queue_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [PC_W-1:0] pc_mem_q    [QDEPTH];
  logic [PC_W-1:0] pc_mem_d    [QDEPTH];
  logic            taken_mem_q [QDEPTH];
  logic            taken_mem_d [QDEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic nonempty;
  logic force_upd;
  logic sel_lookup;
  logic sel_update;
  logic push;

  assign nonempty   = (count_q != '0);
  assign force_upd  = (starve_q == SW'(STARVE_MAX)) && nonempty;
  assign sel_lookup = pred_req && !force_upd;
  assign sel_update = !sel_lookup && nonempty;
  // Ready looks only at the registered count: a full queue does not accept
  // even when the head is popping this cycle.
  assign upd_ready  = (count_q != CW'(QDEPTH));
  assign push       = upd_valid && upd_ready;

  assign pred_grant     = sel_lookup;
  assign pred_rsp_valid = rsp_valid_q;
  assign pred_rsp_taken = rsp_valid_q & tbl_rdata;
  assign queue_count    = count_q;

  assign tbl_en    = sel_lookup | sel_update;
  assign tbl_we    = sel_update;
  assign tbl_pc    = sel_lookup ? pred_pc : (sel_update ? pc_mem_q[head_q] : '0);
  assign tbl_wdata = sel_update & taken_mem_q[head_q];

  always_comb begin
    pc_mem_d    = pc_mem_q;
    taken_mem_d = taken_mem_q;
    tail_d      = tail_q;
    head_d      = head_q;
    if (push) begin
      pc_mem_d[tail_q]    = upd_pc;
      taken_mem_d[tail_q] = upd_taken;
      tail_d              = tail_q + AW'(1);
    end
    // Pop decision uses the pre-push occupancy, so a push into an empty
    // queue is never written out in the same cycle.
    if (sel_update) begin
      head_d = head_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(sel_update);

    // Count lookups that bypass a waiting update; anything else clears it.
    starve_d = '0;
    if (sel_lookup && nonempty) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
    end

    rsp_valid_d = sel_lookup;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        taken_mem_q[i] <= 1'b0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      pc_mem_q    <= pc_mem_d;
      taken_mem_q <= taken_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_bp_access_scheduler.sv
module tb_bp_access_scheduler;

  localparam int PC_W = 10;

  logic            clock = 1'b0;
  logic            reset;
  logic            pred_req;
  logic [PC_W-1:0] pred_pc;
  logic            pred_grant;
  logic            pred_rsp_valid;
  logic            pred_rsp_taken;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_ready;
  logic            tbl_en;
  logic            tbl_we;
  logic [PC_W-1:0] tbl_pc;
  logic            tbl_wdata;
  logic            tbl_rdata;
  logic [2:0]      queue_count;

  int n_checks = 0;
  int n_fail   = 0;

  bp_access_scheduler #(.PC_W(PC_W), .QDEPTH(4), .STARVE_MAX(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_grant     (pred_grant),
    .pred_rsp_valid (pred_rsp_valid),
    .pred_rsp_taken (pred_rsp_taken),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_ready      (upd_ready),
    .tbl_en         (tbl_en),
    .tbl_we         (tbl_we),
    .tbl_pc         (tbl_pc),
    .tbl_wdata      (tbl_wdata),
    .tbl_rdata      (tbl_rdata),
    .queue_count    (queue_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [PC_W-1:0] pc, input logic tk);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = tk;
  endtask

  // Hand-derived write order for the full/wrap scenario (0x104, 0x106, 0x107 are refused).
  logic [PC_W-1:0] wrap_pc [5];
  logic            wrap_tk [5];
  logic            wrap_rdy [8];
  logic [PC_W-1:0] sim_pc [6];
  logic            sim_tk [6];
  logic [2:0]      sim_cnt [6];

  initial begin
    int seen_we;
    int widx;
    int overlap;

    wrap_pc  = '{10'h100, 10'h101, 10'h102, 10'h103, 10'h105};
    wrap_tk  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    wrap_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    sim_pc   = '{10'h020, 10'h021, 10'h022, 10'h023, 10'h024, 10'h025};
    sim_tk   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    sim_cnt  = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};

    reset = 1'b1; pred_req = 1'b0; pred_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; tbl_rdata = 1'b0;

    // Reset values
    #2;
    check("rst_count", queue_count, 0);
    check("rst_ready", upd_ready, 1);
    check("rst_rspv", pred_rsp_valid, 0);
    check("rst_tbl_en", tbl_en, 0);
    pred_req = 1'b1;
    #1;
    check("rst_grant_follows_req", pred_grant, 1);
    pred_req = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Queue three outcomes behind lookups, then reset mid-operation
    pred_req = 1'b1; pred_pc = 10'h111;
    offer(10'h031, 1'b1); next_cycle();
    offer(10'h032, 1'b0); next_cycle();
    offer(10'h033, 1'b1); next_cycle();
    upd_valid = 1'b0;
    check("pre_rst_count", queue_count, 3);
    check("pre_rst_rspv", pred_rsp_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_count", queue_count, 0);
    check("midrst_ready", upd_ready, 1);
    check("midrst_rspv", pred_rsp_valid, 0);
    pred_req = 1'b0;
    next_cycle();
    reset = 1'b0;
    seen_we = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (tbl_we) seen_we++;
      next_cycle();
    end
    check("post_rst_no_writes", seen_we, 0);

    // Lookup, then back-to-back lookups
    pred_req = 1'b1; pred_pc = 10'h3A0;
    @(negedge clock);
    check("lk_grant", pred_grant, 1);
    check("lk_en", tbl_en, 1);
    check("lk_we", tbl_we, 0);
    check("lk_pc", tbl_pc, 10'h3A0);
    next_cycle();
    pred_pc = 10'h3A1; tbl_rdata = 1'b1;
    @(negedge clock);
    check("lk_rspv", pred_rsp_valid, 1);
    check("lk_rsp_taken", pred_rsp_taken, 1);
    check("lk2_pc", tbl_pc, 10'h3A1);
    next_cycle();
    pred_req = 1'b0; tbl_rdata = 1'b0;
    @(negedge clock);
    check("lk2_rspv", pred_rsp_valid, 1);
    check("lk2_rsp_taken", pred_rsp_taken, 0);
    next_cycle();
    check("lk_idle_rspv", pred_rsp_valid, 0);

    // Single update with no lookups
    offer(10'h010, 1'b1);
    next_cycle();
    upd_valid = 1'b0;
    @(negedge clock);
    check("upd_count", queue_count, 1);
    check("upd_we", tbl_we, 1);
    check("upd_pc", tbl_pc, 10'h010);
    check("upd_wdata", tbl_wdata, 1);
    next_cycle();
    @(negedge clock);
    check("upd_drained", queue_count, 0);
    check("upd_idle_en", tbl_en, 0);
    next_cycle();

    // Starvation bound: three lookup grants, then a forced write
    pred_req = 1'b1; pred_pc = 10'h200;
    offer(10'h055, 1'b0);
    next_cycle();
    upd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      check($sformatf("starve_grant%0d", i), pred_grant, 1);
      next_cycle();
    end
    @(negedge clock);
    check("starve_forced_grant", pred_grant, 0);
    check("starve_forced_we", tbl_we, 1);
    check("starve_forced_pc", tbl_pc, 10'h055);
    next_cycle();
    @(negedge clock);
    check("starve_after_grant", pred_grant, 1);
    check("starve_after_we", tbl_we, 0);
    check("starve_after_rspv", pred_rsp_valid, 0);
    check("starve_after_count", queue_count, 0);
    next_cycle();

    // Full queue and pointer wrap under continuous lookups
    pred_pc = 10'h300;
    widx = 0; overlap = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc < 8) offer(10'h100 + PC_W'(cyc), cyc[0]);
      else upd_valid = 1'b0;
      @(negedge clock);
      if (cyc < 8) check($sformatf("wrap_ready%0d", cyc), upd_ready, wrap_rdy[cyc]);
      if (cyc == 4) check("wrap_full_count", queue_count, 4);
      if (tbl_we && pred_grant) overlap++;
      if (tbl_we) begin
        if (widx < 5) begin
          check($sformatf("wrap_pc%0d", widx), tbl_pc, wrap_pc[widx]);
          check($sformatf("wrap_tk%0d", widx), tbl_wdata, wrap_tk[widx]);
        end
        widx++;
      end
      next_cycle();
    end
    check("wrap_write_total", widx, 5);
    check("wrap_rd_wr_overlap", overlap, 0);
    check("wrap_final_count", queue_count, 0);
    pred_req = 1'b0;
    next_cycle();

    // Simultaneous push and pop keeps occupancy steady
    pred_req = 1'b1;
    offer(sim_pc[0], sim_tk[0]); next_cycle();
    offer(sim_pc[1], sim_tk[1]); next_cycle();
    pred_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) offer(sim_pc[i + 2], sim_tk[i + 2]);
      else upd_valid = 1'b0;
      @(negedge clock);
      check($sformatf("sim_count%0d", i), queue_count, sim_cnt[i]);
      check($sformatf("sim_we%0d", i), tbl_we, 1);
      check($sformatf("sim_pc%0d", i), tbl_pc, sim_pc[i]);
      check($sformatf("sim_tk%0d", i), tbl_wdata, sim_tk[i]);
      next_cycle();
    end
    @(negedge clock);
    check("sim_drained", queue_count, 0);
    check("sim_idle_en", tbl_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
